// File: rtl/clock_ce.sv
// Clock-enable and reset sequencer: qualifies DCM lock, releases system reset,
// then emits per-channel fractional clock-enable pulses from phase accumulators.
module clock_ce #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACCW     = 16,
  parameter int unsigned STABLE   = 1024,
  parameter int unsigned CW       = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     locked,
  input  logic [CHANNELS*ACCW-1:0] inc,
  output logic                     ready,
  output logic                     rst_out,
  output logic [CHANNELS-1:0]      ce
);

  typedef enum logic [1:0] {StWait, StCount, StRun} state_e;

  localparam logic [CW-1:0] StableLast = CW'(STABLE - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, s2_q;
  logic          lk;
  logic          run;

  assign lk  = s2_q;
  assign run = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        cnt_d = '0;
        if (lk) state_d = StCount;
      end
      StCount: begin
        if (!lk) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StRun: begin
        if (!lk) state_d = StWait;
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      s1_q    <= locked;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready   = run;
  assign rst_out = ~run;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [ACCW-1:0] acc_q, acc_d;
    logic            ce_q, ce_d;
    logic [ACCW:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc[n*ACCW +: ACCW]};

    // The RUN-exit edge still sees run=1, so one last carry pulse may coincide with ready falling.
    always_comb begin
      acc_d = '0;
      ce_d  = 1'b0;
      if (run) begin
        acc_d = sum[ACCW-1:0];
        ce_d  = sum[ACCW];
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        acc_q <= '0;
        ce_q  <= 1'b0;
      end else begin
        acc_q <= acc_d;
        ce_q  <= ce_d;
      end
    end

    assign ce[n] = ce_q;
  end

endmodule

// File: tb/tb_clock_ce.sv
// Directed testbench for clock_ce with STABLE=4, ACCW=8, two channels.
module tb_clock_ce;

  localparam int unsigned CHANNELS = 2;
  localparam int unsigned ACCW     = 8;
  localparam int unsigned STABLE   = 4;
  localparam int unsigned CW       = 3;

  logic                     clock;
  logic                     reset;
  logic                     locked;
  logic [CHANNELS*ACCW-1:0] inc;
  logic                     ready;
  logic                     rst_out;
  logic [CHANNELS-1:0]      ce;

  int vectors;
  int miscompares;

  clock_ce #(
    .CHANNELS(CHANNELS),
    .ACCW    (ACCW),
    .STABLE  (STABLE),
    .CW      (CW)
  ) u_dut (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .inc    (inc),
    .ready  (ready),
    .rst_out(rst_out),
    .ce     (ce)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected ce (bit1=ch1, bit0=ch0) on the first four RUN edges with inc1=64, inc0=128.
  logic [1:0] start_pat [4];
  initial start_pat = '{2'b00, 2'b01, 2'b00, 2'b11};

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++;
    if (ready !== 1'b0 || rst_out !== 1'b1 || ce !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b rst_out=%b ce=%b, want ready=0 rst_out=1 ce=00",
               ready, rst_out, ce);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad = 0;
    repeat (2000) begin
      @(negedge clock);
      if (ready !== 1'b0 || rst_out !== 1'b1 || ce !== 2'b00) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL idle_no_lock: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_release();
    inc    = {8'd64, 8'd128};
    locked = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clock);
      vectors++;
      if (ready !== (n == 7) || rst_out !== (n != 7)) begin
        miscompares++;
        $display("FAIL release_n%0d: ready=%b rst_out=%b, want ready=%b rst_out=%b",
                 n, ready, rst_out, n == 7, n != 7);
      end
    end
  endtask

  task automatic test_ce_pattern();
    int c0 = 0;
    int c1 = 0;
    int dbl = 0;
    logic [1:0] prev = 2'b00;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (i < 4) begin
        vectors++;
        if (ce !== start_pat[i]) begin
          miscompares++;
          $display("FAIL ce_start_%0d: ce=%b, want %b", i, ce, start_pat[i]);
        end
      end
      if (ce[0]) c0++;
      if (ce[1]) c1++;
      if ((ce & prev) != 2'b00) dbl++;
      prev = ce;
    end
    vectors++;
    if (c0 !== 128) begin
      miscompares++;
      $display("FAIL ce0_rate_128: %0d pulses, want 128", c0);
    end
    vectors++;
    if (c1 !== 64) begin
      miscompares++;
      $display("FAIL ce1_rate_64: %0d pulses, want 64", c1);
    end
    vectors++;
    if (dbl !== 0) begin
      miscompares++;
      $display("FAIL ce_no_back_to_back: %0d double pulses, want 0", dbl);
    end
  endtask

  task automatic test_extreme();
    int c0 = 0;
    int c1 = 0;
    inc = {8'd255, 8'd0};
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (ce[0]) c0++;
      if (ce[1]) c1++;
    end
    vectors++;
    if (c0 !== 0) begin
      miscompares++;
      $display("FAIL ce0_inc_zero: %0d pulses, want 0", c0);
    end
    vectors++;
    if (c1 !== 255) begin
      miscompares++;
      $display("FAIL ce1_inc_255: %0d pulses, want 255", c1);
    end
  endtask

  task automatic test_run_lock_loss();
    locked = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      vectors++;
      if (ready !== (n < 3) || rst_out !== (n >= 3)) begin
        miscompares++;
        $display("FAIL lock_loss_n%0d: ready=%b rst_out=%b, want ready=%b", n, ready, rst_out,
                 n < 3);
      end
      if (n >= 4) begin
        vectors++;
        if (ce !== 2'b00) begin
          miscompares++;
          $display("FAIL lock_loss_ce_n%0d: ce=%b, want 00", n, ce);
        end
      end
    end
  endtask

  task automatic test_count_glitch();
    inc    = {8'd64, 8'd128};
    locked = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clock);
      vectors++;
      if (ready !== (n == 11)) begin
        miscompares++;
        $display("FAIL count_glitch_n%0d: ready=%b, want %b", n, ready, n == 11);
      end
      if (n == 3) locked = 1'b0;
      if (n == 4) locked = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (ce !== start_pat[i]) begin
        miscompares++;
        $display("FAIL glitch_ce_restart_%0d: ce=%b, want %b", i, ce, start_pat[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (ready !== 1'b0 || rst_out !== 1'b1 || ce !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_run_reset: ready=%b rst_out=%b ce=%b, want 0 1 00", ready, rst_out, ce);
    end
    reset = 1'b0;
    for (int m = 1; m <= 7; m++) begin
      @(negedge clock);
      vectors++;
      if (ready !== (m == 7)) begin
        miscompares++;
        $display("FAIL rerelease_m%0d: ready=%b, want %b", m, ready, m == 7);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (ce !== start_pat[i]) begin
        miscompares++;
        $display("FAIL reset_ce_restart_%0d: ce=%b, want %b", i, ce, start_pat[i]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    locked      = 1'b0;
    inc         = '0;
    test_reset();
    test_idle();
    test_release();
    test_ce_pattern();
    test_extreme();
    test_run_lock_loss();
    test_count_glitch();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
